// File: rtl/regfile_pkg.sv
// regfile_pkg: shared types and default sizes for the scoreboarded register file.
package regfile_pkg;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_AW = 5;
    typedef enum logic {IDLE, SWEEP} state_e;
endpackage

// File: rtl/regfile_sb_clr.sv
// regfile_sb_clr: clear-sweep FSM that walks every register address once per clr_req.
module regfile_sb_clr
    import regfile_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          clr_busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);
    state_e        state_q;
    logic [AW-1:0] cnt_q;
    logic          busy_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
            if (clr_req) begin
                state_q <= SWEEP;
                busy_q  <= 1'b1;
            end
        end else begin
            cnt_q <= cnt_q + AW'(1);
            // last address reached: the sweep has covered all DEPTH entries
            if (&cnt_q) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
        end
    end
    assign clr_busy = busy_q;
    assign clr_we   = busy_q;
    assign clr_addr = cnt_q;
endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2R1W register file with write bypass, busy scoreboard and a full-file clear sweep.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int AW       = DEF_AW,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    output logic             rd_busy1,
    output logic             rd_busy2,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr,
    input  logic             clr_req,
    output logic             clr_busy
);
    localparam int DEPTH = 1 << AW;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] busy_q;
    logic             clr_we;
    logic [AW-1:0]    clr_addr;
    logic             wr_live, wr_keep, iss_keep, hit1, hit2;
    regfile_sb_clr #(.AW(AW)) u_clr (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );
    // all external write/issue traffic is dropped while the sweep owns the file
    assign wr_live  = wr_en && !clr_we;
    assign wr_keep  = wr_live && !(ZERO_REG && wr_addr == '0);
    assign iss_keep = issue_en && !clr_we && !(ZERO_REG && issue_addr == '0);
    assign hit1     = wr_live && wr_addr == rd_addr1;
    assign hit2     = wr_live && wr_addr == rd_addr2;
    assign rd_data1 = (hit1 && wr_keep) ? wr_data : mem_q[rd_addr1];
    assign rd_data2 = (hit2 && wr_keep) ? wr_data : mem_q[rd_addr2];
    assign rd_busy1 = busy_q[rd_addr1] && !hit1;
    assign rd_busy2 = busy_q[rd_addr2] && !hit2;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            busy_q <= '0;
        end else if (clr_we) begin
            mem_q[clr_addr]  <= '0;
            busy_q[clr_addr] <= 1'b0;
        end else begin
            if (wr_keep) mem_q[wr_addr] <= wr_data;
            if (wr_live) busy_q[wr_addr] <= 1'b0;
            if (iss_keep) busy_q[issue_addr] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb.
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  rd_addr1 = '0, rd_addr2 = '0, wr_addr = '0, issue_addr = '0;
    logic [31:0] rd_data1, rd_data2, wr_data = '0;
    logic        rd_busy1, rd_busy2, clr_busy;
    logic        wr_en = 1'b0, issue_en = 1'b0, clr_req = 1'b0;
    int          checks = 0;
    int          failures = 0;

    regfile_sb dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr1   (rd_addr1),
        .rd_addr2   (rd_addr2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .rd_busy1   (rd_busy1),
        .rd_busy2   (rd_busy2),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .issue_en   (issue_en),
        .issue_addr (issue_addr),
        .clr_req    (clr_req),
        .clr_busy   (clr_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        checks++;
        if (clr_busy !== 1'b0) begin failures++; $display("FAIL reset_clr_busy got=%b exp=0", clr_busy); end
        tick();
        rst = 1'b1;
        tick();
        for (int i = 0; i < 32; i += 7) begin
            rd_addr1 = 5'(i); rd_addr2 = 5'(31 - i);
            #1;
            checks++;
            if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0 || rd_busy1 !== 1'b0 || rd_busy2 !== 1'b0) begin
                failures++;
                $display("FAIL reset_state addr=%0d d1=%h d2=%h b1=%b b2=%b exp all 0", i, rd_data1, rd_data2, rd_busy1, rd_busy2);
            end
        end
    endtask

    task automatic test_write_read();
        write_reg(5'd5, 32'hDEADBEEF);
        rd_addr1 = 5'd5; rd_addr2 = 5'd5;
        #1;
        checks++;
        if (rd_data1 !== 32'hDEADBEEF || rd_data2 !== 32'hDEADBEEF) begin
            failures++; $display("FAIL write_read d1=%h d2=%h exp=deadbeef", rd_data1, rd_data2);
        end
        rd_addr2 = 5'd0;
        #1;
        checks++;
        if (rd_data2 !== 32'h0) begin failures++; $display("FAIL read_r0 got=%h exp=0", rd_data2); end
    endtask

    task automatic test_bypass();
        rd_addr1 = 5'd7;
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678;
        #1;
        checks++;
        if (rd_data1 !== 32'h12345678 || rd_busy1 !== 1'b0) begin
            failures++; $display("FAIL bypass d1=%h b1=%b exp=12345678/0", rd_data1, rd_busy1);
        end
        tick();
        wr_en = 1'b0;
        #1;
        checks++;
        if (rd_data1 !== 32'h12345678) begin failures++; $display("FAIL bypass_stored got=%h exp=12345678", rd_data1); end
    endtask

    task automatic test_scoreboard();
        rd_addr2 = 5'd3;
        issue_en = 1'b1; issue_addr = 5'd3;
        tick();
        issue_en = 1'b0;
        #1;
        checks++;
        if (rd_busy2 !== 1'b1) begin failures++; $display("FAIL busy_after_issue got=%b exp=1", rd_busy2); end
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
        #1;
        checks++;
        if (rd_busy2 !== 1'b0) begin failures++; $display("FAIL busy_masked_by_write got=%b exp=0", rd_busy2); end
        tick();
        wr_en = 1'b0;
        #1;
        checks++;
        if (rd_busy2 !== 1'b0) begin failures++; $display("FAIL busy_after_write got=%b exp=0", rd_busy2); end
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h44;
        issue_en = 1'b1; issue_addr = 5'd3;
        tick();
        wr_en = 1'b0; issue_en = 1'b0;
        #1;
        checks++;
        if (rd_busy2 !== 1'b1 || rd_data2 !== 32'h44) begin
            failures++; $display("FAIL issue_write_same b2=%b d2=%h exp=1/44", rd_busy2, rd_data2);
        end
    endtask

    task automatic test_zero_reg();
        rd_addr1 = 5'd0;
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        issue_en = 1'b1; issue_addr = 5'd0;
        #1;
        checks++;
        if (rd_data1 !== 32'h0) begin failures++; $display("FAIL r0_bypass got=%h exp=0", rd_data1); end
        tick();
        wr_en = 1'b0; issue_en = 1'b0;
        #1;
        checks++;
        if (rd_data1 !== 32'h0 || rd_busy1 !== 1'b0) begin
            failures++; $display("FAIL r0_stored d1=%h b1=%b exp=0/0", rd_data1, rd_busy1);
        end
    endtask

    task automatic test_clear_sweep();
        int n;
        for (int i = 1; i < 32; i++) write_reg(5'(i), 32'h1000 + i);
        issue_en = 1'b1; issue_addr = 5'd9;
        tick();
        issue_en = 1'b0;
        clr_req = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h22;
        tick();
        clr_req = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hBAD;
        issue_en = 1'b1; issue_addr = 5'd31;
        rd_addr1 = 5'd31; rd_addr2 = 5'd2;
        #1;
        checks++;
        if (rd_data2 !== 32'h22 || clr_busy !== 1'b1) begin
            failures++; $display("FAIL clr_same_cycle_write d2=%h busy=%b exp=22/1", rd_data2, clr_busy);
        end
        n = 0;
        while (clr_busy === 1'b1 && n < 100) begin
            n++;
            checks++;
            if (rd_data1 !== 32'h101F) begin failures++; $display("FAIL sweep_no_bypass cyc=%0d got=%h exp=101f", n, rd_data1); end
            clr_req = (n == 5);
            tick();
        end
        clr_req = 1'b0; wr_en = 1'b0; issue_en = 1'b0;
        checks++;
        if (n !== 32) begin failures++; $display("FAIL sweep_length got=%0d exp=32", n); end
        for (int i = 0; i < 32; i++) begin
            rd_addr1 = 5'(i);
            #1;
            checks++;
            if (rd_data1 !== 32'h0 || rd_busy1 !== 1'b0) begin
                failures++; $display("FAIL after_sweep r%0d d=%h b=%b exp=0/0", i, rd_data1, rd_busy1);
            end
        end
        tick();
        checks++;
        if (clr_busy !== 1'b0) begin failures++; $display("FAIL sweep_restarted got=%b exp=0", clr_busy); end
    endtask

    task automatic test_reset_mid_sweep();
        write_reg(5'd20, 32'h2020);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (10) tick();
        checks++;
        if (clr_busy !== 1'b1) begin failures++; $display("FAIL mid_sweep_busy got=%b exp=1", clr_busy); end
        rst = 1'b0;
        #1;
        checks++;
        if (clr_busy !== 1'b0) begin failures++; $display("FAIL async_reset_busy got=%b exp=0", clr_busy); end
        rd_addr1 = 5'd20;
        #1;
        checks++;
        if (rd_data1 !== 32'h0) begin failures++; $display("FAIL reset_r20 got=%h exp=0", rd_data1); end
        tick();
        rst = 1'b1;
        write_reg(5'd6, 32'h66);
        rd_addr1 = 5'd6;
        #1;
        checks++;
        if (rd_data1 !== 32'h66 || clr_busy !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset d1=%h busy=%b exp=66/0", rd_data1, clr_busy);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_scoreboard();
        test_zero_reg();
        test_clear_sweep();
        test_reset_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
